// File: rtl/idozitett_dekoder_if.sv
// Code/decoded-output bus for idozitett_dekoder.
// Latency: none, the interface only bundles wires.
// Backpressure: in_valid/in_ready handshake on the code side; q/active are never stalled.
interface idozitett_dekoder_if;
  logic [3:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q;
  logic       active;

  // Producer of codes, consumer of the decoded output
  modport master (
    output in, in_valid,
    input  in_ready, q, active
  );

  // The decoder itself
  modport slave (
    input  in, in_valid,
    output in_ready, q, active
  );
endinterface

// File: rtl/idozitett_dekoder.sv
// Timed 3-to-8 decoder: each buffered code drives a one-hot q for HOLD cycles, then GAP zero cycles.
// Latency: a code accepted at edge N into an empty buffer appears on q after edge N+1.
// Backpressure: 2-entry buffer; in_ready is low when it is full (even on a pop cycle) and during reset.
module idozitett_dekoder #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  idozitett_dekoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  localparam logic [7:0] HOLD_LD  = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit         GAP_ZERO = (GAP == 0);

  state_t     state_q;
  logic [7:0] timer_q;
  logic [7:0] q_q;
  logic       active_q;

  logic [2:0] mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic [2:0] head;
  logic       unused_code_bit3;

  // Bit 3 of the code carries no meaning for the decoder
  assign unused_code_bit3 = bus.in[3];

  // Ready depends only on the registered count; reset forces it low
  assign bus.in_ready = !rst && (count_q != 2'd2);
  assign bus.q        = q_q;
  assign bus.active   = active_q;

  // Pop decision: the FSM takes the head only at the points where it starts a new output
  always_comb begin
    fifo_empty = (count_q == 2'd0);
    head       = mem_q[rd_ptr_q];
    push       = bus.in_valid && bus.in_ready;
    pop        = 1'b0;
    case (state_q)
      S_IDLE:   pop = !fifo_empty;
      S_ACTIVE: pop = (timer_q == 8'd0) && GAP_ZERO && !fifo_empty;
      S_GAP:    pop = (timer_q == 8'd0) && !fifo_empty;
      default:  pop = 1'b0;
    endcase
    count_d = count_q + 2'(push) - 2'(pop);
  end

  // Two-entry code buffer; a push and a pop on the same edge both take effect
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.in[2:0];
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Output sequencer: hold each one-hot value, insert the gap, then fetch the next code
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= 8'd0;
      q_q      <= 8'd0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            q_q      <= 8'd1 << head;
            timer_q  <= HOLD_LD;
            active_q <= 1'b1;
            state_q  <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (timer_q != 8'd0) begin
            timer_q <= timer_q - 8'd1;
          end else if (!GAP_ZERO) begin
            q_q      <= 8'd0;
            timer_q  <= GAP_LD;
            active_q <= 1'b0;
            state_q  <= S_GAP;
          end else if (pop) begin
            q_q     <= 8'd1 << head;
            timer_q <= HOLD_LD;
          end else begin
            q_q      <= 8'd0;
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_GAP: begin
          if (timer_q != 8'd0) begin
            timer_q <= timer_q - 8'd1;
          end else if (pop) begin
            q_q      <= 8'd1 << head;
            timer_q  <= HOLD_LD;
            active_q <= 1'b1;
            state_q  <= S_ACTIVE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          q_q      <= 8'd0;
          timer_q  <= 8'd0;
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/idozitett_dekoder.md
IDOZITETT_DEKODER -- requirements
Module: idozitett_dekoder

Interface
REQ-001 The block SHALL have parameter HOLD, default 4, meaning the number of cycles each one-hot output is held (legal 1..255).
REQ-002 The block SHALL have parameter GAP, default 1, meaning the number of all-zero cycles inserted between consecutive outputs (legal 0..255).
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  is the synchronous, active-high reset.
REQ-005 Port in  input  4  is the code to decode; bits [2:0] are the index, bit [3] is ignored.
REQ-006 Port in_valid  input  1  means in holds a code to be accepted.
REQ-007 Port in_ready  output  1  means the block can accept a code this cycle.
REQ-008 Port q  output  8  is the one-hot decoded output; bit n high for index n.
REQ-009 Port active  output  1  is high exactly while q is non-zero.

Function
REQ-010 A code SHALL be accepted at a rising edge where in_valid and in_ready are both high; nothing else changes the buffer.
REQ-011 Accepted codes SHALL enter a 2-entry FIFO and be decoded in acceptance order.
REQ-012 in_ready SHALL be a function of the registered FIFO count only: high when count < 2, low when count = 2, including cycles where a pop occurs.
REQ-013 in_valid while in_ready is low SHALL be ignored, with no change to FIFO contents.
REQ-014 A push and a pop at the same edge SHALL both take effect, leaving count unchanged.
REQ-015 The FSM SHALL have the states IDLE, ACTIVE and GAP, with an 8-bit down-counter timer.
REQ-016 In IDLE with the FIFO non-empty, the next edge SHALL pop the head, load q = 1 << index, load timer = HOLD-1, and enter ACTIVE.
REQ-017 In IDLE with the FIFO empty, the FSM SHALL remain in IDLE with q = 0.
REQ-018 Latency: a code accepted at edge N into an empty FIFO in IDLE SHALL appear on q after edge N+1; the FIFO bypass is not allowed.
REQ-019 In ACTIVE with timer > 0, q SHALL be held and timer decremented by 1.
REQ-020 In ACTIVE with timer = 0 and GAP > 0, the next edge SHALL set q = 0, load timer = GAP-1, and enter GAP.
REQ-021 In ACTIVE with timer = 0, GAP = 0 and the FIFO non-empty, the next edge SHALL pop and stay in ACTIVE with the new q (back-to-back, no zero cycle).
REQ-022 In ACTIVE with timer = 0, GAP = 0 and the FIFO empty, the next edge SHALL set q = 0 and enter IDLE.
REQ-023 In GAP with timer > 0, the FSM SHALL decrement timer with q = 0.
REQ-024 In GAP with timer = 0, the next edge SHALL pop and enter ACTIVE if the FIFO is non-empty, else enter IDLE.
REQ-025 q SHALL have exactly one bit set in ACTIVE and be all zero in IDLE and GAP.
REQ-026 active SHALL be registered and coincide with state ACTIVE.
REQ-027 With HOLD = 1, each code SHALL produce exactly one cycle of q.

Reset
REQ-028 While rst is high at an edge, the block SHALL enter IDLE with q = 0, active = 0, timer = 0 and FIFO count = 0.
REQ-029 Codes presented during reset SHALL be discarded, and in_ready SHALL be low while rst is high.
REQ-030 Reset asserted mid-ACTIVE or mid-GAP SHALL abort immediately; buffered codes are lost.
REQ-031 After rst deasserts, in_ready SHALL be high at the first cycle.

Verification
REQ-032 Single code (HOLD=4, GAP=1): in=3 accepted at edge N -> q=8'h08 and active=1 for edges N+1..N+4; q=0 at N+5 (GAP); IDLE at N+6.
REQ-033 Full-buffer case: push 5, 1, 7 on consecutive cycles while ACTIVE on an earlier code -> in_ready low when count=2, third code held off until a pop, and output order is 8'h20, 8'h02, 8'h80.
REQ-034 Back-to-back (GAP=0, HOLD=2): two codes 0 and 6 buffered -> q=8'h01 for 2 cycles then 8'h40 for 2 cycles with no zero cycle between.
REQ-035 Simultaneous push/pop: count=1, push coincides with a pop from GAP timeout -> count stays 1, and the new code decodes next.
REQ-036 Reset mid-operation: rst during ACTIVE with 2 codes buffered -> next cycle q=0, active=0, in_ready=1 after release; no buffered code is ever output.
REQ-037 Bit-3 ignore: in=4'b1010 -> q=8'h04.
